// File: rtl/qam_readout_arbiter.sv
// rtl/qam_readout_arbiter.sv - round-robin read-out of two QAM demapper FIFOs onto one host port
// One channel is granted at a time and drained for up to BURST_LEN symbols.
module qam_readout_arbiter #(
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 8
) (
  input  logic              dclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ch0_available,
  input  logic              ch0_rdempty,
  output logic              ch0_rdreq,
  input  logic [DATA_W-1:0] ch0_q,
  input  logic              ch1_available,
  input  logic              ch1_rdempty,
  output logic              ch1_rdreq,
  input  logic [DATA_W-1:0] ch1_q,
  output logic [1:0]        grant,
  output logic [DATA_W-1:0] host_data,
  output logic              host_ch,
  output logic              host_valid,
  input  logic              host_ready,
  output logic              burst_done,
  output logic [7:0]        burst_count
);

  typedef enum logic [2:0] {IDLE, READ, FETCH, HOLD, DONE} state_t;

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  state_t              state;
  logic                rr_last;
  logic                gidx;
  logic                g_empty;
  logic [DATA_W-1:0]   g_q;
  logic                rd_go;

  assign gidx    = grant[1];
  assign g_empty = gidx ? ch1_rdempty : ch0_rdempty;
  assign g_q     = gidx ? ch1_q : ch0_q;

  // The read strobe is decoded from the READ state so the FIFO word lands
  // one cycle later, exactly when FETCH captures it.
  assign rd_go     = (state == READ) && enable && !g_empty;
  assign ch0_rdreq = rd_go && grant[0];
  assign ch1_rdreq = rd_go && grant[1];

  always_ff @(posedge dclk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      host_valid  <= 1'b0;
      host_data   <= '0;
      host_ch     <= 1'b0;
      burst_done  <= 1'b0;
      burst_count <= 8'd0;
      rr_last     <= 1'b1;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          grant <= 2'b00;
          if (enable && (ch0_available || ch1_available)) begin
            if (ch0_available && ch1_available)
              grant <= rr_last ? 2'b01 : 2'b10;
            else if (ch0_available)
              grant <= 2'b01;
            else
              grant <= 2'b10;
            burst_count <= 8'd0;
            state       <= READ;
          end
        end
        READ: begin
          if (rd_go) begin
            state <= FETCH;
          end else begin
            burst_done <= 1'b1;
            state      <= DONE;
          end
        end
        FETCH: begin
          host_data  <= g_q;
          host_ch    <= gidx;
          host_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (host_ready) begin
            host_valid  <= 1'b0;
            burst_count <= burst_count + 8'd1;
            if (burst_count + 8'd1 == BURST_MAX) begin
              burst_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= READ;
            end
          end
        end
        DONE: begin
          rr_last <= gidx;
          grant   <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
